// File: rtl/l1_mem_pkg.sv
// Shared types and encodings for the L1-to-L2 request arbiter.
package l1_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DATA = 2'd2
    } l1_state_e;

    localparam logic SRC_ICACHE = 1'b0;
    localparam logic SRC_DCACHE = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/l1_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the requester that did not win last time gets it.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares the L1->L2 request port between Icache refill and Dcache; one owner per transaction.
// state      | meaning
// IDLE       | no owner; pick next requester round-robin
// REQ        | owner's request forwarded, waiting for addrOK
// WAIT_DATA  | read accepted, waiting for dataOK
module l1_mem_arbiter
    import l1_mem_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              icache_mem_req_i,
    input  logic [ADDR_W-1:0] icache_mem_addr_i,
    output logic              mem_icache_addrOK_o,
    output logic              mem_icache_dataOK_o,
    output logic [DATA_W-1:0] mem_icache_data_o,
    input  logic              dcache_mem_req_i,
    input  logic              dcache_mem_wr_i,
    input  logic [1:0]        dcache_mem_size_i,
    input  logic [3:0]        dcache_mem_wstrb_i,
    input  logic [ADDR_W-1:0] dcache_mem_addr_i,
    input  logic [31:0]       dcache_mem_wdata_i,
    output logic              mem_dcache_addrOK_o,
    output logic              mem_dcache_dataOK_o,
    output logic [DATA_W-1:0] mem_dcache_data_o,
    output logic              l1_l2_req_o,
    output logic              l1_l2_src_o,
    output logic              l1_l2_wr_o,
    output logic [1:0]        l1_l2_size_o,
    output logic [3:0]        l1_l2_wstrb_o,
    output logic [ADDR_W-1:0] l1_l2_addr_o,
    output logic [31:0]       l1_l2_wdata_o,
    input  logic              l2_l1_addrOK_i,
    input  logic              l2_l1_dataOK_i,
    input  logic [DATA_W-1:0] l2_l1_data_i
);

    l1_state_e state_q, state_d;
    logic      owner_q, owner_d;
    logic      last_grant_q, last_grant_d;

    logic gnt_valid;
    logic gnt_id;
    logic owner_req;
    logic owner_wr;
    logic active;

    rr_arb2 u_rr_arb2 (
        .req       ({dcache_mem_req_i, icache_mem_req_i}),
        .last      (last_grant_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            owner_q      <= SRC_ICACHE;
            last_grant_q <= SRC_ICACHE;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign owner_req = (owner_q == SRC_DCACHE) ? dcache_mem_req_i : icache_mem_req_i;
    assign owner_wr  = (owner_q == SRC_DCACHE) && dcache_mem_wr_i;
    assign active    = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    owner_d      = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                // a requester that withdraws before acceptance gets no response
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else if (l2_l1_addrOK_i) begin
                    if (owner_wr || l2_l1_dataOK_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (l2_l1_dataOK_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        l1_l2_req_o   = 1'b0;
        l1_l2_src_o   = 1'b0;
        l1_l2_wr_o    = 1'b0;
        l1_l2_size_o  = SIZE_B;
        l1_l2_wstrb_o = 4'b0000;
        l1_l2_addr_o  = '0;
        l1_l2_wdata_o = 32'd0;
        if (active) begin
            l1_l2_src_o = owner_q;
        end
        if (state_q == ST_REQ) begin
            l1_l2_req_o = owner_req;
            if (owner_q == SRC_DCACHE) begin
                l1_l2_wr_o    = dcache_mem_wr_i;
                l1_l2_size_o  = dcache_mem_size_i;
                l1_l2_wstrb_o = dcache_mem_wstrb_i;
                l1_l2_addr_o  = dcache_mem_addr_i;
                l1_l2_wdata_o = dcache_mem_wdata_i;
            end else begin
                l1_l2_size_o  = SIZE_W;
                l1_l2_addr_o  = icache_mem_addr_i;
            end
        end
    end

    assign mem_icache_addrOK_o = active && (owner_q == SRC_ICACHE) && l2_l1_addrOK_i;
    assign mem_icache_dataOK_o = active && (owner_q == SRC_ICACHE) && l2_l1_dataOK_i;
    assign mem_dcache_addrOK_o = active && (owner_q == SRC_DCACHE) && l2_l1_addrOK_i;
    assign mem_dcache_dataOK_o = active && (owner_q == SRC_DCACHE) && l2_l1_dataOK_i;
    assign mem_icache_data_o   = l2_l1_data_i;
    assign mem_dcache_data_o   = l2_l1_data_i;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_l1_mem_arbiter;

    logic         clk;
    logic         rstn;
    logic         ireq;
    logic [31:0]  iaddr;
    logic         i_aok, i_dok;
    logic [127:0] i_data;
    logic         dreq, dwr;
    logic [1:0]   dsize;
    logic [3:0]   dwstrb;
    logic [31:0]  daddr, dwdata;
    logic         d_aok, d_dok;
    logic [127:0] d_data;
    logic         oreq, osrc, owr;
    logic [1:0]   osize;
    logic [3:0]   owstrb;
    logic [31:0]  oaddr, owdata;
    logic         l2_aok, l2_dok;
    logic [127:0] l2_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    l1_mem_arbiter #(.DATA_W(128), .ADDR_W(32)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .icache_mem_req_i    (ireq),
        .icache_mem_addr_i   (iaddr),
        .mem_icache_addrOK_o (i_aok),
        .mem_icache_dataOK_o (i_dok),
        .mem_icache_data_o   (i_data),
        .dcache_mem_req_i    (dreq),
        .dcache_mem_wr_i     (dwr),
        .dcache_mem_size_i   (dsize),
        .dcache_mem_wstrb_i  (dwstrb),
        .dcache_mem_addr_i   (daddr),
        .dcache_mem_wdata_i  (dwdata),
        .mem_dcache_addrOK_o (d_aok),
        .mem_dcache_dataOK_o (d_dok),
        .mem_dcache_data_o   (d_data),
        .l1_l2_req_o         (oreq),
        .l1_l2_src_o         (osrc),
        .l1_l2_wr_o          (owr),
        .l1_l2_size_o        (osize),
        .l1_l2_wstrb_o       (owstrb),
        .l1_l2_addr_o        (oaddr),
        .l1_l2_wdata_o       (owdata),
        .l2_l1_addrOK_i      (l2_aok),
        .l2_l1_dataOK_i      (l2_dok),
        .l2_l1_data_i        (l2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Transaction-level model: busy/owner/accepted plus who won last.
    bit m_busy, m_owner, m_last, m_acc;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 0; m_owner = 0; m_last = 0; m_acc = 0;
        end else if (!m_busy) begin
            if (ireq || dreq) begin
                m_owner = (ireq && dreq) ? !m_last : dreq;
                m_last  = m_owner;
                m_busy  = 1;
                m_acc   = 0;
            end
        end else if (!m_acc) begin
            if (!(m_owner ? dreq : ireq)) m_busy = 0;
            else if (l2_aok) begin
                if ((m_owner && dwr) || l2_dok) m_busy = 0;
                else m_acc = 1;
            end
        end else if (l2_dok) begin
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        logic        e_req, e_src, e_wr;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_addr, e_wdata;
        logic        fwd;
        e_req = 0; e_src = 0; e_wr = 0; e_size = 0; e_wstrb = 0; e_addr = 0; e_wdata = 0;
        fwd = m_busy && !m_acc;
        if (m_busy) e_src = m_owner;
        if (fwd) begin
            e_req = m_owner ? dreq : ireq;
            if (m_owner) begin
                e_wr = dwr; e_size = dsize; e_wstrb = dwstrb; e_addr = daddr; e_wdata = dwdata;
            end else begin
                e_size = 2; e_addr = iaddr;
            end
        end
        chk("m_req",   oreq,   e_req);
        chk("m_src",   osrc,   e_src);
        chk("m_wr",    owr,    e_wr);
        chk("m_size",  osize,  e_size);
        chk("m_wstrb", owstrb, e_wstrb);
        chk("m_addr",  oaddr,  e_addr);
        chk("m_wdata", owdata, e_wdata);
        chk("m_i_aok", i_aok, m_busy && !m_owner && l2_aok);
        chk("m_i_dok", i_dok, m_busy && !m_owner && l2_dok);
        chk("m_d_aok", d_aok, m_busy && m_owner && l2_aok);
        chk("m_d_dok", d_dok, m_busy && m_owner && l2_dok);
        chk("m_i_data", i_data, l2_data);
        chk("m_d_data", d_data, l2_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        l2_aok  = 0;
        l2_dok  = 0;
        l2_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        rstn = 0; ireq = 0; iaddr = 0; dreq = 0; dwr = 0; dsize = 0; dwstrb = 0;
        daddr = 0; dwdata = 0; l2_aok = 0; l2_dok = 0; l2_data = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", oreq, 0);
        chk("rst_src", osrc, 0);
        chk("rst_oks", {i_aok, i_dok, d_aok, d_dok}, 0);
        rstn = 1;
        tick();

        // single Icache read
        ireq = 1; iaddr = 32'h1C00_0040;
        tick();
        #1 chk("ird_req", {oreq, osrc, owr, osize}, {1'b1, 1'b0, 1'b0, 2'd2});
        chk("ird_addr", oaddr, 32'h1C00_0040);
        tick();
        l2_aok = 1;
        #1 chk("ird_aok", {i_aok, d_aok, oreq}, 3'b101);
        tick();
        ireq = 0;
        #1 chk("ird_wait_req", oreq, 0);
        tick();
        tick();
        l2_dok = 1; l2_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        #1 chk("ird_dok", {i_dok, d_dok}, 2'b10);
        chk("ird_data", i_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        tick();

        // tie after reset: Dcache first, with same-cycle addrOK+dataOK
        ireq = 1; dreq = 1; dwr = 0; dsize = 2; daddr = 32'h8000_1000;
        tick();
        #1 chk("tie1_src", {oreq, osrc}, 2'b11);
        l2_aok = 1; l2_dok = 1;
        #1 chk("tie1_oks", {d_aok, d_dok, i_aok, i_dok}, 4'b1100);
        tick();
        dreq = 0;
        #1 chk("tie1_idle", oreq, 0);
        tick();
        #1 chk("tie1_i_gnt", {oreq, osrc}, 2'b10);
        l2_aok = 1;
        tick();
        ireq = 0; l2_dok = 1;
        tick();
        ireq = 1; dreq = 1;
        tick();
        #1 chk("tie2_src", {oreq, osrc}, 2'b11);
        l2_aok = 1; l2_dok = 1;
        tick();
        dreq = 0;
        tick();
        l2_aok = 1;
        tick();
        ireq = 0; l2_dok = 1;
        tick();

        // Dcache uncached write with Icache pending
        dreq = 1; dwr = 1; dsize = 0; dwstrb = 4'b0100; daddr = 32'hBFD0_0002; dwdata = 32'h0000_AB00;
        tick();
        #1 chk("wr_fields", {oreq, osrc, owr, osize, owstrb}, {1'b1, 1'b1, 1'b1, 2'd0, 4'b0100});
        chk("wr_addr", {oaddr, owdata}, {32'hBFD0_0002, 32'h0000_AB00});
        ireq = 1; iaddr = 32'h1C00_0080;
        tick();
        tick();
        l2_aok = 1;
        #1 chk("wr_aok", {d_aok, d_dok, i_aok}, 3'b100);
        tick();
        dreq = 0; dwr = 0;
        #1 chk("wr_idle", {oreq, osrc}, 2'b00);
        tick();
        #1 chk("wr_i_gnt", {oreq, osrc, oaddr}, {1'b1, 1'b0, 32'h1C00_0080});
        l2_aok = 1;
        tick();
        ireq = 0; l2_dok = 1;
        tick();

        // Dcache abandons before acceptance, then a stray addrOK in IDLE
        dreq = 1; daddr = 32'h0000_0100; dsize = 1;
        tick();
        #1 chk("ab_req", {oreq, osrc}, 2'b11);
        dreq = 0;
        #1 chk("ab_drop", oreq, 0);
        tick();
        l2_aok = 1;
        #1 chk("ab_stray", {d_aok, i_aok}, 2'b00);
        tick();

        // reset while waiting for data, then a stray dataOK
        ireq = 1; iaddr = 32'h1C00_00C0;
        tick();
        l2_aok = 1;
        tick();
        ireq = 0;
        #2 chk("rw_src_before", osrc, 0);
        l2_data = 0; l2_dok = 1; rstn = 0;
        #1 chk("rw_outs", {oreq, osrc, i_aok, i_dok, d_aok, d_dok}, 0);
        chk("rw_data", i_data, 0);
        tick();
        rstn = 1; l2_dok = 1;
        #1 chk("rw_stray", {i_dok, d_dok}, 2'b00);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Shares the single L1→L2 request port between the Icache refill FSM (read-only) and the Dcache main FSM (reads, write-through stores, strongly-ordered uncached accesses). Sits between the two L1 controllers and the L2 cache. It grants one requester at a time, round-robin, and holds the grant for the whole transaction. It forwards the request, steers `addrOK`/`dataOK`/data back to the owner, and keeps the non-owner's handshake outputs low.

## Interface
- `DATA_W`, 128: refill line width returned by L2 (`32 << offset_width`).
- `ADDR_W`, 32: physical address width.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `icache_mem_req`  in  1  Icache read request, held until `mem_icache_addrOK`.
- `icache_mem_addr`  in  ADDR_W  Icache line address.
- `mem_icache_addrOK`  out  1  request accepted.
- `mem_icache_dataOK`  out  1  refill data valid.
- `mem_icache_data`  out  DATA_W  refill data.
- `dcache_mem_req`  in  1  Dcache request, held until `mem_dcache_addrOK`.
- `dcache_mem_wr`  in  1  1 = write, 0 = read.
- `dcache_mem_size`  in  2  0 = byte, 1 = half, 2 = word.
- `dcache_mem_wstrb`  in  4  byte write enables.
- `dcache_mem_addr`  in  ADDR_W  address.
- `dcache_mem_wdata`  in  32  store data.
- `mem_dcache_addrOK`  out  1  request accepted (write complete).
- `mem_dcache_dataOK`  out  1  read data valid.
- `mem_dcache_data`  out  DATA_W  read data.
- `l1_l2_req`  out  1  request to L2.
- `l1_l2_src`  out  1  0 = Icache, 1 = Dcache.
- `l1_l2_wr`, `l1_l2_size`, `l1_l2_wstrb`, `l1_l2_addr`, `l1_l2_wdata`  out  1/2/4/ADDR_W/32  forwarded fields. Icache grant forces wr=0, size=2, wstrb=0, wdata=0.
- `l2_l1_addrOK`  in  1  L2 accepted request; for writes, write complete.
- `l2_l1_dataOK`  in  1  L2 read data valid.
- `l2_l1_data`  in  DATA_W  L2 read data.

## Operation
- **States:**
  - IDLE: no owner.
  - REQ: owner's request forwarded, waiting for `addrOK`.
  - WAIT_DATA: read accepted, waiting for `dataOK`.
- **Registers:** `state`, `owner`, `last_grant`.
- **IDLE:**
  - Only one req high: grant it.
  - Both high: grant the one not equal to `last_grant`.
  - On grant: `owner` <= grantee, `last_grant` <= grantee, go to REQ.
- **REQ:**
  - `l1_l2_req` = owner's live req; fields are taken combinationally from the owner.
  - On `l2_l1_addrOK`:
    - Write: go to IDLE.
    - Read with `l2_l1_dataOK` in the same cycle: go to IDLE.
    - Read otherwise: go to WAIT_DATA.
  - Owner drops req before `addrOK`: abandon, go to IDLE, no response.
- **WAIT_DATA:**
  - `l1_l2_req` = 0.
  - On `l2_l1_dataOK`: go to IDLE.
- **Response steering:**
  - `addrOK` and `dataOK` are forwarded combinationally, only to `owner`, and only in REQ/WAIT_DATA.
  - The non-owner's OK outputs are always 0.
  - Data buses are driven with `l2_l1_data` to both requesters; the OK flags qualify them.
- **Strays:** `addrOK` or `dataOK` arriving in IDLE is ignored.
- **Reset:**
  - Mid-transaction reset returns to IDLE and drops `l1_l2_req` immediately.
  - `last_grant` = 0 (Icache), so the Dcache wins the first tie.

## Timing
- Reset values: all outputs 0; `state` = IDLE; `owner` = 0; `last_grant` = 0.
- Grant latency:
  - req high in IDLE at cycle N → `l1_l2_req` high at N+1.
  - Req rising while not IDLE waits for return to IDLE.
- `addrOK`/`dataOK`/data: 0-cycle combinational pass-through to the owner.
- Turnaround: one IDLE cycle minimum between transactions; back-to-back same-requester throughput is 1 transaction per (L2 latency + 2) cycles.
- Fairness: with both requesting continuously, grants alternate strictly.

## Structure
- Shared package `l1_mem_pkg`:
  - state encoding (IDLE=0, REQ=1, WAIT_DATA=2);
  - `SRC_ICACHE=0`, `SRC_DCACHE=1`;
  - size codes `SIZE_B/H/W`.
- Sub-module `rr_arb2`: combinational 2-way round-robin pick. Inputs `req[1:0]` and `last`; outputs `gnt_valid` and `gnt_id`. Reused later for the L2 side.

## Test plan
- **Single Icache read:** Icache req at cycle 1 with addr 0x1C000040; L2 `addrOK` at 3, `dataOK` at 6 → `l1_l2_req` high cycles 2–3 with src=0, wr=0, size=2; `mem_icache_addrOK` at 3; `mem_icache_dataOK` at 6 with data; Dcache OKs stay 0.
- **Tie after reset:** both request at cycle 1 → Dcache granted first (src=1); Icache granted in the IDLE following Dcache completion; a following tie goes to the Dcache.
- **Dcache uncached write:** wr=1, size=0, wstrb=0100, addr 0xBFD0_0002, wdata 0x0000_AB00; `addrOK` at 4 → FSM returns to IDLE at 5 with no WAIT_DATA; Icache pending is granted at 5.
- **Same-cycle addrOK+dataOK on a read** → both OKs forwarded in one cycle; next state IDLE.
- **Reset mid-WAIT_DATA and stray dataOK:** `rstn` low mid-WAIT_DATA → all outputs 0 asynchronously; a stray `dataOK` after reset produces no requester OK.
